chrono_ctrl: RTL

Control and timekeeping core that produces every input `seven_seg` consumes: mode (`state`, `tm_state`), `edit_place`, and the four BCD digits. It debounces four raw push-buttons, runs an HH:MM:SS clock and an MM:SS countdown timer, and applies digit edits. It sits between the board buttons and `seven_seg`, with outputs wired port-for-port.

---
 rtl/chrono_pkg.sv | 46 ++++
 rtl/chrono_ctrl_if.sv | 24 ++
 rtl/chrono_ctrl_btn_debounce.sv | 37 +++
 rtl/chrono_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/chrono_pkg.sv
// Shared mode encodings, BCD limits and two-digit BCD helpers for chrono_ctrl.
package chrono_pkg;
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_SET = 2'd1, ST_TIMER = 2'd2} mode_t;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] o;
    } bcd2_t;

    localparam logic [3:0] HR_T_MAX = 4'd2;
    localparam logic [3:0] HR_O_MAX = 4'd3;
    localparam logic [3:0] MS_T_MAX = 4'd5;
    localparam logic [3:0] MS_O_MAX = 4'd9;

    localparam int B_MODE  = 0;
    localparam int B_START = 1;
    localparam int B_PLACE = 2;
    localparam int B_INC   = 3;

    function automatic bcd2_t bcd_inc(bcd2_t v, logic [3:0] lim_t, logic [3:0] lim_o);
        bcd2_t r;
        if (v.t == lim_t && v.o == lim_o) begin
            r = '0;
        end else if (v.o == 4'd9) begin
            r.t = v.t + 4'd1;
            r.o = 4'd0;
        end else begin
            r.t = v.t;
            r.o = v.o + 4'd1;
        end
        return r;
    endfunction

    // Only meaningful for v != 00; the caller handles the pair borrow.
    function automatic bcd2_t bcd_dec(bcd2_t v);
        bcd2_t r;
        if (v.o == 4'd0) begin
            r.t = v.t - 4'd1;
            r.o = 4'd9;
        end else begin
            r.t = v.t;
            r.o = v.o - 4'd1;
        end
        return r;
    endfunction
endpackage

// File: rtl/chrono_ctrl_if.sv
// Board-side bundle: raw buttons in, mode/place/BCD digits out to the display.
interface chrono_ctrl_if;
    logic       btn_mode;
    logic       btn_place;
    logic       btn_inc;
    logic       btn_start;
    logic [1:0] state;
    logic       tm_state;
    logic       edit_place;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic       timer_done;

    modport master (
        output btn_mode, btn_place, btn_inc, btn_start,
        input  state, tm_state, edit_place, ones, tens, hundreds, thousands, timer_done
    );
    modport slave (
        input  btn_mode, btn_place, btn_inc, btn_start,
        output state, tm_state, edit_place, ones, tens, hundreds, thousands, timer_done
    );
endinterface

// File: rtl/chrono_ctrl_btn_debounce.sv
// Two-FF synchronizer plus stability counter; one-cycle pulse per accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            pulse <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync[1];
                cnt    <= '0;
                pulse  <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/chrono_ctrl.sv
// Mode FSM, 1 Hz tick, HH:MM:SS clock, MM:SS countdown and registered digit mux.
module chrono_ctrl
    import chrono_pkg::*;
#(
    parameter int SEC_DIV         = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic          clk_100MHz,
    input logic          reset,
    chrono_ctrl_if.slave bus
);
    localparam int TW = $clog2(SEC_DIV + 1);

    logic [3:0]    raw, pulse;
    logic [TW-1:0] tcnt;
    logic          tick, do_mode, do_start, do_place, do_inc, cnt_dn, dn_zero;
    mode_t         mode;
    logic          tm, ep, done;
    bcd2_t         hh, mm, ss, tmm, tss, tmm_dn, tss_dn, dhi, dlo;

    assign raw = {bus.btn_inc, bus.btn_place, bus.btn_start, bus.btn_mode};

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk_100MHz), .rst(reset), .raw(raw[i]), .pulse(pulse[i])
        );
    end

    assign do_mode  = pulse[B_MODE];
    assign do_start = pulse[B_START] & ~do_mode;
    assign do_place = pulse[B_PLACE] & ~do_mode & ~pulse[B_START];
    assign do_inc   = pulse[B_INC] & ~do_mode & ~pulse[B_START] & ~pulse[B_PLACE];
    assign tick     = (tcnt == TW'(SEC_DIV - 1));
    // A start or mode pulse on a tick cycle wins over that tick's decrement.
    assign cnt_dn   = tick && (mode == ST_TIMER) && tm && !do_mode && !do_start;

    always_comb begin
        tss_dn = bcd_dec(tss);
        tmm_dn = tmm;
        if (tss == '0) begin
            tss_dn = {MS_T_MAX, MS_O_MAX};
            tmm_dn = bcd_dec(tmm);
        end
    end
    assign dn_zero = ({tmm_dn, tss_dn} == '0);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
            mode <= ST_RUN;
            tm   <= 1'b0;
            ep   <= 1'b0;
            done <= 1'b0;
            hh   <= '0;
            mm   <= '0;
            ss   <= '0;
            tmm  <= '0;
            tss  <= '0;
        end else begin
            tcnt <= tick ? '0 : tcnt + 1'b1;
            if (|pulse) done <= 1'b0;
            if (tick && mode != ST_SET) begin
                ss <= bcd_inc(ss, MS_T_MAX, MS_O_MAX);
                if (ss == {MS_T_MAX, MS_O_MAX}) begin
                    mm <= bcd_inc(mm, MS_T_MAX, MS_O_MAX);
                    if (mm == {MS_T_MAX, MS_O_MAX}) hh <= bcd_inc(hh, HR_T_MAX, HR_O_MAX);
                end
            end
            if (do_mode) begin
                ep <= 1'b0;
                tm <= 1'b0;
                case (mode)
                    ST_RUN: mode <= ST_SET;
                    ST_SET: begin
                        mode <= ST_TIMER;
                        ss   <= '0;
                    end
                    default: mode <= ST_RUN;
                endcase
            end else if (do_start) begin
                if (mode == ST_TIMER) begin
                    if (tm) tm <= 1'b0;
                    else if ({tmm, tss} != '0) tm <= 1'b1;
                end
            end else if (do_place) begin
                if (mode == ST_SET || (mode == ST_TIMER && !tm)) ep <= ~ep;
            end else if (do_inc) begin
                if (mode == ST_SET) begin
                    if (ep) hh <= bcd_inc(hh, HR_T_MAX, HR_O_MAX);
                    else    mm <= bcd_inc(mm, MS_T_MAX, MS_O_MAX);
                end else if (mode == ST_TIMER && !tm) begin
                    if (ep) tmm <= bcd_inc(tmm, MS_T_MAX, MS_O_MAX);
                    else    tss <= bcd_inc(tss, MS_T_MAX, MS_O_MAX);
                end
            end
            if (cnt_dn) begin
                tmm <= tmm_dn;
                tss <= tss_dn;
                if (dn_zero) begin
                    done <= 1'b1;
                    tm   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            dhi <= '0;
            dlo <= '0;
        end else if (mode == ST_TIMER) begin
            dhi <= tmm;
            dlo <= tss;
        end else begin
            dhi <= hh;
            dlo <= mm;
        end
    end

    assign bus.state      = mode;
    assign bus.tm_state   = tm;
    assign bus.edit_place = ep;
    assign bus.timer_done = done;
    assign bus.thousands  = dhi.t;
    assign bus.hundreds   = dhi.o;
    assign bus.tens       = dlo.t;
    assign bus.ones       = dlo.o;
endmodule
